// File: rtl/regfile_pkg.sv
// Shared constants, write-port record and ring-distance helper for the
// register-file write-back path.
package regfile_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;
    localparam int NREQ_DEF = 4;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } wb_port_t;

    // Scan-order position of idx when scanning starts at base on a ring of n.
    function automatic int ring_dist(input int idx, input int base, input int n);
        return (idx >= base) ? (idx - base) : (idx + n - base);
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_pick.sv
// Round-robin picker: the first set bit of (req & ~excl) at or after ptr,
// wrapping around modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    // Scan from the far end backwards so the nearest hit is the final assignment.
    always_comb begin
        int          j;
        logic [PW-1:0] jj;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = PW'(j);
            if (cand[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin merge of NREQ results onto two register
// file write ports. Optional stall statistics under `WB_SCHED_STATS_EN.
module regfile_wb_sched #(
    parameter int NREQ = regfile_pkg::NREQ_DEF,
    parameter int XLEN = regfile_pkg::XLEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*5-1:0]      req_rd,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   we1,
    output logic                   we2,
    output logic [4:0]             rd1,
    output logic [4:0]             rd2,
    output logic [XLEN-1:0]        wdata1,
    output logic [XLEN-1:0]        wdata2,
    output logic [31:0]            pending_mask,
    output logic [31:0]            stall_count
);

    import regfile_pkg::*;

    localparam int PW = $clog2(NREQ);

    // Same fields as wb_port_t, sized by this instance's data width.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   wdata;
    } port_t;

    logic [REG_AW-1:0] rd_arr   [NREQ];
    logic [XLEN-1:0]   data_arr [NREQ];
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   g1_oh;
    logic [NREQ-1:0]   same_rd;
    logic [NREQ-1:0]   excl2;
    logic [NREQ-1:0]   skip;
    logic              g1_found, g2_found;
    logic [PW-1:0]     g1_idx, g2_idx;
    logic              conflict;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_base;
    logic [PW-1:0]     ptr_nxt;
    port_t             p1, p2;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rd_arr[i]   = req_rd[REG_AW*i +: REG_AW];
            data_arr[i] = req_data[XLEN*i +: XLEN];
            elig[i]     = req_valid[i] && (req_rd[REG_AW*i +: REG_AW] != '0);
        end
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_pick_g1 (
        .req   (elig),
        .ptr   (ptr),
        .excl  ('0),
        .found (g1_found),
        .idx   (g1_idx)
    );

    // Anything sharing G1's destination is held back from port 2 this cycle.
    always_comb begin
        g1_oh   = '0;
        same_rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            g1_oh[i]   = g1_found && (g1_idx == PW'(i));
            same_rd[i] = elig[i] && (g1_idx != PW'(i)) && (rd_arr[i] == rd_arr[g1_idx]);
        end
    end

    assign excl2 = same_rd | g1_oh;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick_g2 (
        .req   (elig),
        .ptr   (ptr),
        .excl  (excl2),
        .found (g2_found),
        .idx   (g2_idx)
    );

    // A same-rd request counts as skipped only if the scan passed it before G2.
    always_comb begin
        skip = '0;
        for (int i = 0; i < NREQ; i++) begin
            skip[i] = same_rd[i] &&
                      (!g2_found ||
                       (ring_dist(i, int'(ptr), NREQ) < ring_dist(int'(g2_idx), int'(ptr), NREQ)));
        end
    end

    assign conflict = g1_found && (|skip);
    assign ptr_base = (conflict || !g2_found) ? g1_idx : g2_idx;
    assign ptr_nxt  = (ptr_base == PW'(NREQ - 1)) ? '0 : ptr_base + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = !reset && req_valid[i] &&
                           ((rd_arr[i] == '0) ||
                            (g1_found && (g1_idx == PW'(i))) ||
                            (g2_found && (g2_idx == PW'(i))));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            p1  <= '0;
            p2  <= '0;
        end else begin
            p1.we    <= g1_found;
            p1.rd    <= g1_found ? rd_arr[g1_idx]   : '0;
            p1.wdata <= g1_found ? data_arr[g1_idx] : '0;
            p2.we    <= g2_found;
            p2.rd    <= g2_found ? rd_arr[g2_idx]   : '0;
            p2.wdata <= g2_found ? data_arr[g2_idx] : '0;
            if (g1_found) ptr <= ptr_nxt;
        end
    end

    assign we1    = p1.we;
    assign rd1    = p1.rd;
    assign wdata1 = p1.wdata;
    assign we2    = p2.we;
    assign rd2    = p2.rd;
    assign wdata2 = p2.wdata;

    always_comb begin
        pending_mask = '0;
        if (p1.we) pending_mask[p1.rd] = 1'b1;
        if (p2.we) pending_mask[p2.rd] = 1'b1;
    end

`ifdef WB_SCHED_STATS_EN
    logic [31:0] stall_cnt;
    logic        stall_any;

    assign stall_any = |(req_valid & ~req_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_any && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_count = stall_cnt;
`else
    assign stall_count = '0;
`endif

endmodule
